// File: rtl/time_set_sequencer.sv
// Time-set controller: button debounce plus HH:MM edit state machine
// driving the timekeeping counter load and the display blink/select.
module time_set_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_S       = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pb,
  input  logic       tick_1hz,
  input  logic [3:0] cur_hu,
  input  logic [3:0] cur_hl,
  input  logic [3:0] cur_mu,
  input  logic [3:0] cur_ml,
  output logic [3:0] hu,
  output logic [3:0] hl,
  output logic [3:0] mu,
  output logic [3:0] ml,
  output logic       load,
  output logic       setup_mode,
  output logic [1:0] loc,
  output logic       blink
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_PRE = CW'(DEBOUNCE_CYCLES - 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S - 1);

  localparam logic [2:0] RUN    = 3'd0;
  localparam logic [2:0] SET_HU = 3'd1;
  localparam logic [2:0] SET_HL = 3'd2;
  localparam logic [2:0] SET_MU = 3'd3;
  localparam logic [2:0] SET_ML = 3'd4;
  localparam logic [2:0] COMMIT = 3'd5;

  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] ev;
  logic [3:0] ev_pri;

  // Synchronisers reset high so a button held through reset stays locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 4'hF;
      s2_q <= 4'hF;
    end else begin
      s1_q <= pb;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt_q;
    logic          lock_q;
    logic          ev_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        lock_q <= 1'b1;
        ev_q   <= 1'b0;
      end else begin
        ev_q <= 1'b0;
        if (!s2_q[i]) begin
          cnt_q  <= '0;
          lock_q <= 1'b0;
        end else if (!lock_q && cnt_q != DB_MAX) begin
          cnt_q <= cnt_q + CW'(1);
          ev_q  <= (cnt_q == DB_PRE);
        end
      end
    end

    assign ev[i] = ev_q;
  end

  always_comb begin
    ev_pri = 4'b0000;
    if (ev[0])      ev_pri = 4'b0001;
    else if (ev[1]) ev_pri = 4'b0010;
    else if (ev[2]) ev_pri = 4'b0100;
    else if (ev[3]) ev_pri = 4'b1000;
  end

  function automatic logic [3:0] step(
    input logic [3:0] v,
    input logic [3:0] max,
    input logic       up
  );
    logic [3:0] r;
    if (up) r = (v >= max) ? 4'd0 : v + 4'd1;
    else    r = (v == 4'd0 || v > max) ? max : v - 4'd1;
    return r;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [3:0]    hu_q, hu_d;
  logic [3:0]    hl_q, hl_d;
  logic [3:0]    mu_q, mu_d;
  logic [3:0]    ml_q, ml_d;
  logic          blink_q, blink_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0]    hl_max;
  logic          up;

  assign hl_max = (hu_q == 4'd2) ? 4'd3 : 4'd9;
  assign up     = ev_pri[2];

  always_comb begin
    state_d = state_q;
    hu_d    = hu_q;
    hl_d    = hl_q;
    mu_d    = mu_q;
    ml_d    = ml_q;
    blink_d = blink_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        tcnt_d  = '0;
        if (ev_pri[0]) begin
          hu_d    = cur_hu;
          hl_d    = cur_hl;
          mu_d    = cur_mu;
          ml_d    = cur_ml;
          blink_d = 1'b1;
          state_d = SET_HU;
        end
      end
      SET_HU, SET_HL, SET_MU, SET_ML: begin
        if (tick_1hz) blink_d = ~blink_q;
        if (|ev_pri) begin
          tcnt_d = '0;
          unique case (1'b1)
            ev_pri[0]: begin
              blink_d = 1'b0;
              state_d = COMMIT;
            end
            ev_pri[1]: begin
              blink_d = 1'b1;
              case (state_q)
                SET_HU:  state_d = SET_HL;
                SET_HL:  state_d = SET_MU;
                SET_MU:  state_d = SET_ML;
                default: state_d = SET_HU;
              endcase
            end
            ev_pri[2], ev_pri[3]: begin
              case (state_q)
                SET_HU: begin
                  hu_d = step(hu_q, 4'd2, up);
                  if (hu_d == 4'd2 && hl_q > 4'd3) hl_d = 4'd3;
                end
                SET_HL:  hl_d = step(hl_q, hl_max, up);
                SET_MU:  mu_d = step(mu_q, 4'd5, up);
                default: ml_d = step(ml_q, 4'd9, up);
              endcase
            end
            default: ;
          endcase
        end else if (tick_1hz) begin
          // Abort leaves the edit registers untouched and issues no load.
          if (tcnt_q == TO_LAST) begin
            tcnt_d  = '0;
            blink_d = 1'b0;
            state_d = RUN;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      COMMIT: begin
        blink_d = 1'b0;
        state_d = RUN;
      end
      default: begin
        blink_d = 1'b0;
        tcnt_d  = '0;
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hu_q    <= '0;
      hl_q    <= '0;
      mu_q    <= '0;
      ml_q    <= '0;
      blink_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hu_q    <= hu_d;
      hl_q    <= hl_d;
      mu_q    <= mu_d;
      ml_q    <= ml_d;
      blink_q <= blink_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    setup_mode = 1'b1;
    loc        = 2'd0;
    case (state_q)
      SET_HU:  loc = 2'd3;
      SET_HL:  loc = 2'd2;
      SET_MU:  loc = 2'd1;
      SET_ML:  loc = 2'd0;
      default: setup_mode = 1'b0;
    endcase
  end

  assign load  = (state_q == COMMIT);
  assign blink = blink_q;
  assign hu    = hu_q;
  assign hl    = hl_q;
  assign mu    = mu_q;
  assign ml    = ml_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed bench for time_set_sequencer: vector table of button presses
// plus hand sequences for timeout, simultaneous events and reset.
module tb_time_set_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pb;
  logic        tick;
  logic [15:0] cur;
  logic [3:0]  hu, hl, mu, ml;
  logic        load, setup_mode, blink;
  logic [1:0]  loc;
  logic [15:0] dig;

  int nvec  = 0;
  int nerr  = 0;
  int nload = 0;

  always #5 clk = ~clk;

  time_set_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_S(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pb(pb),
    .tick_1hz(tick),
    .cur_hu(cur[15:12]),
    .cur_hl(cur[11:8]),
    .cur_mu(cur[7:4]),
    .cur_ml(cur[3:0]),
    .hu(hu),
    .hl(hl),
    .mu(mu),
    .ml(ml),
    .load(load),
    .setup_mode(setup_mode),
    .loc(loc),
    .blink(blink)
  );

  assign dig = {hu, hl, mu, ml};

  always @(negedge clk) if (load === 1'b1) nload++;

  typedef struct {
    logic [3:0]  pb;
    logic [15:0] cur;
    logic [15:0] dig;
    logic        setup;
    logic [1:0]  loc;
    int          loads;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk) pb = m;
    repeat (10) @(negedge clk);
    pb = 4'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0001, 16'h1347, 16'h1347, 1'b1, 2'd3, 0};
    tbl[1]  = '{4'b0001, 16'h2159, 16'h1347, 1'b0, 2'd0, 1};
    tbl[2]  = '{4'b0001, 16'h1905, 16'h1905, 1'b1, 2'd3, 1};
    tbl[3]  = '{4'b0100, 16'h2159, 16'h2305, 1'b1, 2'd3, 1};
    tbl[4]  = '{4'b0100, 16'h2159, 16'h0305, 1'b1, 2'd3, 1};
    tbl[5]  = '{4'b0001, 16'h2159, 16'h0305, 1'b0, 2'd0, 2};
    tbl[6]  = '{4'b0001, 16'h0000, 16'h0000, 1'b1, 2'd3, 2};
    tbl[7]  = '{4'b0010, 16'h2159, 16'h0000, 1'b1, 2'd2, 2};
    tbl[8]  = '{4'b0010, 16'h2159, 16'h0000, 1'b1, 2'd1, 2};
    tbl[9]  = '{4'b0010, 16'h2159, 16'h0000, 1'b1, 2'd0, 2};
    tbl[10] = '{4'b1000, 16'h2159, 16'h0009, 1'b1, 2'd0, 2};
    tbl[11] = '{4'b0010, 16'h2159, 16'h0009, 1'b1, 2'd3, 2};
    tbl[12] = '{4'b1000, 16'h2159, 16'h2009, 1'b1, 2'd3, 2};
    tbl[13] = '{4'b0001, 16'h2159, 16'h2009, 1'b0, 2'd0, 3};
    tbl[14] = '{4'b0001, 16'h2300, 16'h2300, 1'b1, 2'd3, 3};
    tbl[15] = '{4'b0010, 16'h2159, 16'h2300, 1'b1, 2'd2, 3};
    tbl[16] = '{4'b0100, 16'h2159, 16'h2000, 1'b1, 2'd2, 3};
    tbl[17] = '{4'b1000, 16'h2159, 16'h2300, 1'b1, 2'd2, 3};
    tbl[18] = '{4'b0010, 16'h2159, 16'h2300, 1'b1, 2'd1, 3};
    tbl[19] = '{4'b1000, 16'h2159, 16'h2350, 1'b1, 2'd1, 3};
    tbl[20] = '{4'b0010, 16'h2159, 16'h2350, 1'b1, 2'd0, 3};
    tbl[21] = '{4'b0100, 16'h2159, 16'h2351, 1'b1, 2'd0, 3};
    tbl[22] = '{4'b0010, 16'h2159, 16'h2351, 1'b1, 2'd3, 3};
    tbl[23] = '{4'b1000, 16'h2159, 16'h1351, 1'b1, 2'd3, 3};
    tbl[24] = '{4'b0001, 16'h2159, 16'h1351, 1'b0, 2'd0, 4};

    rst  = 1'b1;
    pb   = 4'b0;
    tick = 1'b0;
    cur  = 16'h0000;
    repeat (4) @(negedge clk);
    chk("reset_digits", dig, 16'h0000);
    chk("reset_ctrl", 16'({load, setup_mode, loc, blink}), 16'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Short glitch must not qualify.
    pb = 4'b0001;
    repeat (3) @(negedge clk);
    pb = 4'b0;
    repeat (12) @(negedge clk);
    chk("short_press_setup", 16'(setup_mode), 16'h0);
    chk("short_press_load", 16'(nload), 16'd0);

    for (int i = 0; i < 25; i++) begin
      cur = tbl[i].cur;
      press(tbl[i].pb);
      chk($sformatf("v%0d_digits", i), dig, tbl[i].dig);
      chk($sformatf("v%0d_setup", i), 16'(setup_mode), 16'(tbl[i].setup));
      chk($sformatf("v%0d_loc", i), 16'(loc), 16'(tbl[i].loc));
      chk($sformatf("v%0d_loads", i), 16'(nload), 16'(tbl[i].loads));
    end

    // Timeout in SET_MU.
    cur = 16'h1234;
    press(4'b0001);
    press(4'b0010);
    press(4'b0010);
    press(4'b0100);
    chk("to_digits", dig, 16'h1244);
    chk("to_loc", 16'(loc), 16'd1);
    chk("to_blink0", 16'(blink), 16'd1);
    pulse_tick();
    chk("to_tick1_blink", 16'(blink), 16'd0);
    chk("to_tick1_setup", 16'(setup_mode), 16'd1);
    pulse_tick();
    chk("to_tick2_blink", 16'(blink), 16'd1);
    chk("to_tick2_setup", 16'(setup_mode), 16'd1);
    pulse_tick();
    chk("to_abort_setup", 16'(setup_mode), 16'd0);
    chk("to_abort_digits", dig, 16'h1244);
    chk("to_abort_blink", 16'(blink), 16'd0);
    chk("to_abort_loads", 16'(nload), 16'd4);

    // Press event coincident with the final tick wins.
    cur = 16'h1000;
    press(4'b0001);
    chk("race_enter", 16'(setup_mode), 16'd1);
    pulse_tick();
    pulse_tick();
    @(negedge clk) pb = 4'b0100;
    repeat (6) @(posedge clk);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (4) @(negedge clk);
    pb = 4'b0;
    repeat (5) @(negedge clk);
    chk("race_setup", 16'(setup_mode), 16'd1);
    chk("race_digits", dig, 16'h2000);
    pulse_tick();
    chk("race_cleared", 16'(setup_mode), 16'd1);

    // Simultaneous next-digit and increment: only next-digit taken.
    press(4'b0110);
    chk("simul_loc", 16'(loc), 16'd2);
    chk("simul_digits", dig, 16'h2000);

    // Reset in SET_HL.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_digits", dig, 16'h0000);
    chk("midrst_ctrl", 16'({load, setup_mode, loc, blink}), 16'h0);
    repeat (3) @(negedge clk);
    chk("midrst_loads", 16'(nload), 16'd4);

    // Button held through reset needs a release first.
    cur = 16'h0812;
    @(negedge clk) begin
      pb  = 4'b0001;
      rst = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_rst_setup", 16'(setup_mode), 16'd0);
    pb = 4'b0;
    repeat (5) @(negedge clk);
    press(4'b0001);
    chk("after_release_setup", 16'(setup_mode), 16'd1);
    chk("after_release_digits", dig, 16'h0812);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
